rs_arith_unit: RTL and testbench
================================

Name: rs_arith_unit

Overview:
- Single-issue integer functional unit attached to one reservation-station entry of the out-of-order core.
- Waits until both source operands of its entry are resolved (no pending producer tags).
- Computes value1 + value2 or value1 − value2, then broadcasts the 32-bit result with a one-cycle valid pulse on the common data bus slot of its tag.
- The core's Add units (tags 1-4) and Sub units (tags 5-7) are this block with OP fixed.

Parameters:
- OP, 0, operation select: 0 = add (value1 + value2), 1 = subtract (value1 − value2).
- LATENCY, 1, cycles from operand-ready sample to result_available pulse; legal range 1..8.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- RSTN_N  input  1  reset, asynchronous, active-low.
- rstation  input  ReservationStation (cpu_pkg)  this unit's entry, with fields:
  - busy (1): the entry holds an issued instruction.
  - alu1 (8): producer tag of operand 1; 0 means ready.
  - alu2 (8): producer tag of operand 2; 0 means ready.
  - value1 (32): operand 1 value.
  - value2 (32): operand 2 value.
- result  output  32  computed value; valid while result_available = 1, held afterwards.
- result_available  output  1  one-cycle broadcast strobe.

Behaviour:
- Reset (RSTN_N low, asynchronous): state = IDLE; result = 32'h0; result_available = 0; latency counter cleared. These hold while RSTN_N is low.
- State machine, evaluated each rising clk edge:
  - IDLE → EXEC when busy = 1, alu1 = 0 and alu2 = 0 are sampled together. On that edge latch value1 and value2, and load the counter with LATENCY−1.
  - EXEC: decrement the counter. When the counter is 0 on an edge:
    - result <= latched value1 ± latched value2, modulo 2^32 (wrap, no overflow or borrow flag, no sign handling).
    - result_available <= 1.
    - Go to DONE.
  - With LATENCY = 1, the pulse appears on the edge after the operand-ready sample.
  - DONE: result_available <= 0, so the pulse is exactly one cycle. Stay in DONE while busy = 1. Go to IDLE on the first edge where busy = 0.
- Exactly one broadcast per busy episode. An entry that stays busy after completion must never trigger a second pulse.
- Operand changes after the IDLE → EXEC latch are ignored. Tags becoming 0 while in IDLE are picked up on the next sample; no minimum ready time is required.
- busy dropping in EXEC (flush): abort, return to IDLE, no pulse. result keeps its previous value.
- busy = 0 with both tags 0 in IDLE: no action.
- Back-to-back issue: after DONE → IDLE, a new ready entry may be accepted on the very next edge.
- result changes only on a completion edge; between pulses it holds the last value.
- Reset asserted mid-operation: immediate return to reset values; an in-flight result is discarded.
- No combinational path from rstation to either output.

Decomposition:
- cpu_pkg holds:
  - typedef inst (32-bit logic).
  - ReservationStation packed struct {busy, alu1[7:0], alu2[7:0], value1, value2}.
  - Tag width constant (8).
  - Data width constant (32).
- Add and Sub are thin wrappers instantiating rs_arith_unit with OP = 0 and OP = 1, keeping the core's existing instance port names (rstation, result, result_available, clk, RSTN_N).
- No further sub-module; the state machine and datapath live in rs_arith_unit.

Test Plan:
- Add, LATENCY = 1:
  - Stimulus: busy = 1, alu1 = alu2 = 0, value1 = 5, value2 = 7.
  - Response: result = 12 with result_available high for exactly one cycle, one edge later. No further pulse while busy stays 1.
- Sub wrap, OP = 1:
  - Stimulus: value1 = 3, value2 = 5.
  - Response: result = 32'hFFFFFFFE. Also value1 = 32'hFFFFFFFF plus value2 = 1 with OP = 0 gives result = 0.
- Pending tags:
  - Stimulus: busy = 1, alu1 = 2, value1 = 0, value2 = 9; three cycles later alu1 = 0 and value1 = 4.
  - Response: no pulse before the tag clears. Then one pulse with result = 13 (add) or −5 = 32'hFFFFFFFB (sub).
- Re-issue:
  - Stimulus: complete 1 + 1 = 2, drop busy one cycle, re-issue 10 + 20.
  - Response: second pulse with result = 30. result holds 2 between the pulses.
- LATENCY = 3 plus flush:
  - Stimulus: issue 8 + 8; in one run drop busy during EXEC.
  - Response: normal run pulses 16 exactly 3 edges after the ready sample. Flushed run produces no pulse and result is unchanged.
- Async reset mid-EXEC:
  - Stimulus: assert RSTN_N low between clock edges while in EXEC.
  - Response: result = 0 and result_available = 0 immediately. No pulse after release until a new ready issue arrives.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core types: reservation-station entry layout and datapath widths.
package cpu_pkg;

  localparam int unsigned TagWidth   = 8;
  localparam int unsigned DataWidth  = 32;
  localparam int unsigned MaxLatency = 8;
  localparam int unsigned CntWidth   = $clog2(MaxLatency);

  typedef logic [31:0] inst;

  typedef struct packed {
    logic                 busy;
    logic [TagWidth-1:0]  alu1;
    logic [TagWidth-1:0]  alu2;
    logic [DataWidth-1:0] value1;
    logic [DataWidth-1:0] value2;
  } ReservationStation;

  // Wrapping add/subtract; no carry or borrow is reported.
  function automatic logic [DataWidth-1:0] arith_op(input logic sub,
                                                    input logic [DataWidth-1:0] a,
                                                    input logic [DataWidth-1:0] b);
    return sub ? (a - b) : (a + b);
  endfunction

endpackage

// File: rtl/Add.sv
// Add functional unit: rs_arith_unit fixed to value1 + value2.
module Add
  import cpu_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 RSTN_N,
  input  ReservationStation    rstation,
  output logic [DataWidth-1:0] result,
  output logic                 result_available
);

  rs_arith_unit #(
    .OP      (0),
    .LATENCY (LATENCY)
  ) u_unit (
    .clk              (clk),
    .RSTN_N           (RSTN_N),
    .rstation         (rstation),
    .result           (result),
    .result_available (result_available)
  );

endmodule

// File: rtl/Sub.sv
// Sub functional unit: rs_arith_unit fixed to value1 - value2.
module Sub
  import cpu_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 RSTN_N,
  input  ReservationStation    rstation,
  output logic [DataWidth-1:0] result,
  output logic                 result_available
);

  rs_arith_unit #(
    .OP      (1),
    .LATENCY (LATENCY)
  ) u_unit (
    .clk              (clk),
    .RSTN_N           (RSTN_N),
    .rstation         (rstation),
    .result           (result),
    .result_available (result_available)
  );

endmodule

// File: rtl/rs_arith_unit.sv
// Reservation-station arithmetic unit: waits for both operands, computes add or sub,
// then broadcasts the result with a single-cycle strobe.
module rs_arith_unit
  import cpu_pkg::*;
#(
  parameter int unsigned OP      = 0,
  parameter int unsigned LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 RSTN_N,
  input  ReservationStation    rstation,
  output logic [DataWidth-1:0] result,
  output logic                 result_available
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [DataWidth-1:0]  op1_q, op1_d;
  logic [DataWidth-1:0]  op2_q, op2_d;
  logic [DataWidth-1:0]  result_q, result_d;
  logic                  avail_q, avail_d;
  logic                  ready;

  assign ready = rstation.busy && (rstation.alu1 == '0) && (rstation.alu2 == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    result_d = result_q;
    avail_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ready) begin
          op1_d   = rstation.value1;
          op2_d   = rstation.value2;
          cnt_d   = CntWidth'(LATENCY - 1);
          state_d = StExec;
        end
      end
      StExec: begin
        // A flush wins over a completion landing on the same edge.
        if (!rstation.busy) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          result_d = arith_op(OP != 0, op1_q, op2_q);
          avail_d  = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (!rstation.busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge RSTN_N) begin
    if (!RSTN_N) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
      avail_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
      avail_q  <= avail_d;
    end
  end

  assign result           = result_q;
  assign result_available = avail_q;

endmodule

// File: tb/tb_rs_arith_unit.sv
// Bench: Add (lat 1), Sub (lat 1) and an add unit with lat 3 share one entry stimulus;
// a completion-time model checks every cycle, directed literals pin the model.
module tb_rs_arith_unit;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              RSTN_N = 1'b0;
  ReservationStation rs;
  logic [31:0]       res [3];
  logic              av  [3];

  int checks = 0;
  int errors = 0;

  // Model state per unit: index 0 add/lat1, 1 sub/lat1, 2 add/lat3.
  int unsigned lat   [3] = '{1, 1, 3};
  bit          is_sub[3] = '{1'b0, 1'b1, 1'b0};
  longint      due   [3];
  bit          served[3];
  logic [31:0] pend  [3];
  logic [31:0] exp_res[3];
  logic        exp_av [3];
  longint      cyc = 0;

  always #5 clk = ~clk;

  Add u_add (
    .clk              (clk),
    .RSTN_N           (RSTN_N),
    .rstation         (rs),
    .result           (res[0]),
    .result_available (av[0])
  );

  Sub u_sub (
    .clk              (clk),
    .RSTN_N           (RSTN_N),
    .rstation         (rs),
    .result           (res[1]),
    .result_available (av[1])
  );

  rs_arith_unit #(
    .OP      (0),
    .LATENCY (3)
  ) u_l3 (
    .clk              (clk),
    .RSTN_N           (RSTN_N),
    .rstation         (rs),
    .result           (res[2]),
    .result_available (av[2])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      due[k]     = -1;
      served[k]  = 1'b0;
      exp_res[k] = 32'h0;
      exp_av[k]  = 1'b0;
    end
  endtask

  // One rising edge of the spec: a ready entry completes lat edges later unless flushed;
  // after completion the unit ignores the entry until busy has been seen low.
  task automatic model_edge();
    if (!RSTN_N) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      exp_av[k] = 1'b0;
      if (due[k] >= 0) begin
        if (!rs.busy) begin
          due[k] = -1;
        end else if (cyc == due[k]) begin
          exp_res[k] = pend[k];
          exp_av[k]  = 1'b1;
          due[k]     = -1;
          served[k]  = 1'b1;
        end
      end else if (served[k]) begin
        if (!rs.busy) served[k] = 1'b0;
      end else if (rs.busy && rs.alu1 == 0 && rs.alu2 == 0) begin
        due[k]  = cyc + longint'(lat[k]);
        pend[k] = is_sub[k] ? rs.value1 - rs.value2 : rs.value1 + rs.value2;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("model_result_u%0d", k), res[k], exp_res[k]);
      check($sformatf("model_avail_u%0d", k), {31'b0, av[k]}, {31'b0, exp_av[k]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_rs(input logic b, input logic [7:0] t1, input logic [7:0] t2,
                        input logic [31:0] v1, input logic [31:0] v2);
    rs.busy   = b;
    rs.alu1   = t1;
    rs.alu2   = t2;
    rs.value1 = v1;
    rs.value2 = v2;
  endtask

  task automatic episode(input logic [31:0] v1, input logic [31:0] v2, input int hold);
    set_rs(1'b1, 8'd0, 8'd0, v1, v2);
    repeat (hold) tick();
    rs.busy = 1'b0;
    tick();
  endtask

  initial begin
    set_rs(1'b0, 8'd0, 8'd0, 32'd0, 32'd0);
    model_reset();
    repeat (2) tick();
    check("reset_result", res[0], 32'h0);
    check("reset_avail", {31'b0, av[2]}, 32'h0);
    @(negedge clk);
    RSTN_N = 1'b1;
    tick();

    // 5 + 7 with latency 1 and 3; busy held afterwards must not re-fire.
    set_rs(1'b1, 8'd0, 8'd0, 32'd5, 32'd7);
    tick();
    check("add1_not_yet", {31'b0, av[0]}, 32'h0);
    tick();
    check("add_5p7", res[0], 32'd12);
    check("add_5p7_pulse", {31'b0, av[0]}, 32'h1);
    check("sub_5m7", res[1], 32'hFFFF_FFFE);
    tick();
    check("add_pulse_one_cycle", {31'b0, av[0]}, 32'h0);
    check("l3_not_yet", {31'b0, av[2]}, 32'h0);
    tick();
    check("l3_5p7", res[2], 32'd12);
    check("l3_5p7_pulse", {31'b0, av[2]}, 32'h1);
    repeat (4) tick();
    rs.busy = 1'b0;
    tick();

    // Wrap-around cases.
    episode(32'd3, 32'd5, 5);
    check("sub_wrap", res[1], 32'hFFFF_FFFE);
    check("add_3p5", res[0], 32'd8);
    episode(32'hFFFF_FFFF, 32'd1, 5);
    check("add_wrap", res[0], 32'h0);

    // Pending producer tag, operand arrives with the tag clearing.
    set_rs(1'b1, 8'd2, 8'd0, 32'd0, 32'd9);
    repeat (3) tick();
    check("pending_no_result", res[0], 32'h0);
    set_rs(1'b1, 8'd0, 8'd0, 32'd4, 32'd9);
    repeat (5) tick();
    check("pending_add", res[0], 32'd13);
    check("pending_sub", res[1], 32'hFFFF_FFFB);
    check("pending_l3", res[2], 32'd13);
    rs.busy = 1'b0;
    tick();

    // Re-issue after one idle cycle.
    episode(32'd1, 32'd1, 5);
    check("reissue_first", res[0], 32'd2);
    set_rs(1'b1, 8'd0, 8'd0, 32'd10, 32'd20);
    tick();
    check("reissue_hold", res[0], 32'd2);
    tick();
    check("reissue_second", res[0], 32'd30);
    repeat (3) tick();
    rs.busy = 1'b0;
    tick();

    // Flush during EXEC of the latency-3 unit.
    set_rs(1'b1, 8'd0, 8'd0, 32'd8, 32'd8);
    tick();
    tick();
    rs.busy = 1'b0;
    repeat (4) tick();
    check("flush_keeps_result", res[2], 32'd30);
    check("flush_lat1_done", res[0], 32'd16);
    set_rs(1'b1, 8'd0, 8'd0, 32'd8, 32'd8);
    repeat (3) tick();
    check("l3_edge2_quiet", {31'b0, av[2]}, 32'h0);
    tick();
    check("l3_8p8", res[2], 32'd16);
    check("l3_8p8_pulse", {31'b0, av[2]}, 32'h1);
    rs.busy = 1'b0;
    tick();

    // Asynchronous reset in the middle of EXEC.
    set_rs(1'b1, 8'd0, 8'd0, 32'd8, 32'd8);
    tick();
    tick();
    #1;
    RSTN_N  = 1'b0;
    rs.busy = 1'b0;
    #1;
    check("async_rst_result", res[2], 32'h0);
    check("async_rst_avail", {31'b0, av[2]}, 32'h0);
    check("async_rst_add", res[0], 32'h0);
    model_reset();
    repeat (2) tick();
    RSTN_N = 1'b1;
    repeat (4) tick();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rs.busy   = ($urandom_range(0, 7) != 0);
      rs.alu1   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 7)) : 8'd0;
      rs.alu2   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 7)) : 8'd0;
      rs.value1 = $urandom;
      rs.value2 = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
